oc_bus_arbiter: RTL

OC_BUS_ARBITER -- requirements
Module: oc_bus_arbiter

---
 rtl/oc_bus_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/oc_bus_arbiter.sv
// Round-robin arbiter for a wired open-collector line with hold timeout.
// Ports: clk, clr (async, active-high), req[3:0], bus (sensed line level);
// outputs gnt[3:0] one-hot, owner[1:0], busy, tmo (pulse), err (sticky).
module oc_bus_arbiter #(
  parameter int MAXHOLD = 15,
  parameter int TURN    = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] req,
  input  logic       bus,
  output logic [3:0] gnt,
  output logic [1:0] owner,
  output logic       busy,
  output logic       tmo,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  localparam logic [7:0] LP_MAX  = 8'(MAXHOLD);
  localparam logic [3:0] LP_TURN = 4'(TURN);

  state_t     r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_owner;
  logic [1:0] r_ptr;
  logic       r_busy;
  logic       r_tmo;
  logic       r_err;
  logic [7:0] r_hold;
  logic [3:0] r_turn;

  logic       w_any;
  logic [1:0] w_win;

  // Scan from the farthest offset down so the
  // nearest requester at or after r_ptr wins.
  always_comb begin
    w_any = |req;
    w_win = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[r_ptr + 2'(k)]) begin
        w_win = r_ptr + 2'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_gnt   <= 4'b0000;
      r_owner <= 2'd0;
      r_ptr   <= 2'd0;
      r_busy  <= 1'b0;
      r_tmo   <= 1'b0;
      r_err   <= 1'b0;
      r_hold  <= 8'd0;
      r_turn  <= 4'd0;
    end else begin
      r_tmo <= 1'b0;
      // Line pulled low with nobody granted: stuck driver.
      if (r_state == S_IDLE && !bus) begin
        r_err <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_GRANT;
            r_gnt   <= 4'b0001 << w_win;
            r_owner <= w_win;
            r_ptr   <= w_win + 2'd1;
            r_hold  <= 8'd1;
            r_busy  <= 1'b1;
          end
        end
        S_GRANT: begin
          if (!req[r_owner]) begin
            r_state <= S_RECOVER;
            r_gnt   <= 4'b0000;
            r_hold  <= 8'd0;
            r_turn  <= 4'd1;
          end else if (r_hold == LP_MAX) begin
            r_state <= S_RECOVER;
            r_gnt   <= 4'b0000;
            r_hold  <= 8'd0;
            r_turn  <= 4'd1;
            r_tmo   <= 1'b1;
          end else begin
            r_hold <= r_hold + 8'd1;
          end
        end
        S_RECOVER: begin
          // r_turn counts RECOVER cycles, saturating at TURN
          // so a stuck-low line can wait forever.
          if (r_turn >= LP_TURN && bus) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_turn  <= 4'd0;
          end else if (r_turn < LP_TURN) begin
            r_turn <= r_turn + 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= 4'b0000;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign owner = r_owner;
  assign busy  = r_busy;
  assign tmo   = r_tmo;
  assign err   = r_err;

endmodule
